// File: rtl/player_pkg.sv
// Shared types and screen constants for the player ship
// and its bullet pool.
package player_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    OVER = 2'd2
  } play_state_e;

  localparam int BULLET_W = 6;
  localparam int BULLET_H = 10;
  localparam int SCREEN_W = 640;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: active flag plus top/left registers.
// Retire wins over load and over the per-frame step.
module bullet_slot #(
  parameter int LAUNCH_TOP_P  = 384,
  parameter int BULLET_STEP_P = 10
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       load_i,
  input  logic [9:0] left_i,
  input  logic       frame_i,
  input  logic       retire_i,
  output logic       active_o,
  output logic [9:0] top_o,
  output logic [9:0] left_o
);

  logic       active_q;
  logic [9:0] top_q;
  logic [9:0] left_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_q <= 1'b0;
      top_q    <= 10'(LAUNCH_TOP_P);
      left_q   <= '0;
    end else if (retire_i) begin
      active_q <= 1'b0;
    end else if (load_i) begin
      active_q <= 1'b1;
      top_q    <= 10'(LAUNCH_TOP_P);
      left_q   <= left_i;
    end else if (active_q && frame_i) begin
      if (top_q <= 10'(BULLET_STEP_P)) begin
        active_q <= 1'b0;
      end else begin
        top_q <= top_q - 10'(BULLET_STEP_P);
      end
    end
  end

  assign active_o = active_q;
  assign top_o    = top_q;
  assign left_o   = left_q;

endmodule

// File: rtl/player_cannon.sv
// Player ship: position, lives, play/hit/over FSM and a
// pool of bullet slots with a shared reload cooldown.
module player_cannon
  import player_pkg::*;
#(
  parameter int BULLETS_P      = 2,
  parameter int SHIP_W_P       = 40,
  parameter int STEP_P         = 5,
  parameter int BULLET_STEP_P  = 10,
  parameter int LEFT_BORDER_P  = 9,
  parameter int RIGHT_BORDER_P = 629,
  parameter int START_POS_P    = 300,
  parameter int LAUNCH_TOP_P   = 384,
  parameter int START_LIVES_P  = 2,
  parameter int MAX_LIVES_P    = 3,
  parameter int COOLDOWN_P     = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    frame_i,
  input  logic                    move_left_i,
  input  logic                    move_right_i,
  input  logic                    shoot_i,
  input  logic                    hit_i,
  input  logic                    add_life_i,
  input  logic [BULLETS_P-1:0]    hit_enemy_i,
  output logic [1:0]              state_o,
  output logic                    alive_o,
  output logic [1:0]              lives_o,
  output logic [9:0]              pos_left_o,
  output logic [9:0]              pos_right_o,
  output logic [BULLETS_P-1:0]    bullet_active_o,
  output logic [10*BULLETS_P-1:0] bullet_left_o,
  output logic [10*BULLETS_P-1:0] bullet_top_o,
  output logic                    fired_o
);

  play_state_e state_q;
  logic [1:0]  lives_q;
  logic [9:0]  pos_q;
  logic [7:0]  cool_q;
  logic        shoot_q;
  logic        shoot_prev_q;
  logic        fired_q;

  logic                 shoot_edge;
  logic                 play;
  logic                 clear;
  logic                 launch;
  logic                 found;
  logic                 life_up;
  logic [1:0]           lives_inc;
  logic [9:0]           left_pos;
  logic [9:0]           right_pos;
  logic [9:0]           launch_left;
  logic [BULLETS_P-1:0] active;
  logic [BULLETS_P-1:0] retire;
  logic [BULLETS_P-1:0] free;
  logic [BULLETS_P-1:0] sel;
  logic [BULLETS_P-1:0] load;

  assign shoot_edge = shoot_q & ~shoot_prev_q;
  assign play       = (state_q == PLAY);
  assign clear      = ~play | hit_i;
  assign retire     = hit_enemy_i | {BULLETS_P{clear}};
  // A slot retiring this cycle must not be handed out again.
  assign free       = ~active & ~retire;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < BULLETS_P; k++) begin
      if (free[k] && !found) begin
        sel[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign launch = play & ~hit_i & shoot_edge
                & (cool_q == 8'd0) & found;
  assign load   = sel & {BULLETS_P{launch}};
  assign launch_left = pos_q
                     + 10'(SHIP_W_P / 2 - BULLET_W / 2);

  assign left_pos =
    ({1'b0, pos_q} < 11'(LEFT_BORDER_P + STEP_P))
      ? 10'(LEFT_BORDER_P)
      : pos_q - 10'(STEP_P);
  assign right_pos =
    (({1'b0, pos_q} + 11'(STEP_P))
       > 11'(RIGHT_BORDER_P - SHIP_W_P))
      ? 10'(RIGHT_BORDER_P - SHIP_W_P)
      : pos_q + 10'(STEP_P);

  assign life_up   = add_life_i & frame_i & (state_q != OVER);
  assign lives_inc = (lives_q == 2'(MAX_LIVES_P))
                   ? lives_q : lives_q + 2'd1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= PLAY;
      lives_q      <= 2'(START_LIVES_P);
      pos_q        <= 10'(START_POS_P);
      cool_q       <= '0;
      shoot_q      <= 1'b0;
      shoot_prev_q <= 1'b0;
      fired_q      <= 1'b0;
    end else begin
      shoot_q      <= shoot_i;
      shoot_prev_q <= shoot_q;
      fired_q      <= launch;
      unique case (state_q)
        PLAY: begin
          if (launch) begin
            cool_q <= 8'(COOLDOWN_P);
          end else if (frame_i && cool_q != 8'd0) begin
            cool_q <= cool_q - 8'd1;
          end
          if (hit_i) begin
            if (lives_q != 2'd0) begin
              state_q <= HIT;
              lives_q <= life_up ? lives_q : lives_q - 2'd1;
            end else begin
              state_q <= OVER;
            end
          end else begin
            if (life_up) lives_q <= lives_inc;
            if (frame_i && (move_left_i ^ move_right_i)) begin
              pos_q <= move_left_i ? left_pos : right_pos;
            end
          end
        end
        HIT: begin
          cool_q <= '0;
          if (life_up) lives_q <= lives_inc;
          if (shoot_edge) begin
            state_q <= PLAY;
            pos_q   <= 10'(START_POS_P);
          end
        end
        OVER: begin
          cool_q <= '0;
          if (shoot_edge) begin
            state_q <= PLAY;
            lives_q <= 2'(START_LIVES_P);
            pos_q   <= 10'(START_POS_P);
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  for (genvar g = 0; g < BULLETS_P; g++) begin : g_slot
    bullet_slot #(
      .LAUNCH_TOP_P (LAUNCH_TOP_P),
      .BULLET_STEP_P(BULLET_STEP_P)
    ) u_slot (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .load_i  (load[g]),
      .left_i  (launch_left),
      .frame_i (frame_i),
      .retire_i(retire[g]),
      .active_o(active[g]),
      .top_o   (bullet_top_o[10*g +: 10]),
      .left_o  (bullet_left_o[10*g +: 10])
    );
  end

  assign state_o         = state_q;
  assign alive_o         = (state_q != OVER);
  assign lives_o         = lives_q;
  assign pos_left_o      = pos_q;
  assign pos_right_o     = pos_q + 10'(SHIP_W_P);
  assign bullet_active_o = active;
  assign fired_o         = fired_q;

endmodule

// File: tb/tb_player_cannon.sv
// Directed bench for player_cannon with default parameters:
// movement clamps, launches, flight, hits and async reset.
module tb_player_cannon;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        frame_i = 1'b0;
  logic        move_left_i = 1'b0;
  logic        move_right_i = 1'b0;
  logic        shoot_i = 1'b0;
  logic        hit_i = 1'b0;
  logic        add_life_i = 1'b0;
  logic [1:0]  hit_enemy_i = 2'b00;
  logic [1:0]  state_o;
  logic        alive_o;
  logic [1:0]  lives_o;
  logic [9:0]  pos_left_o;
  logic [9:0]  pos_right_o;
  logic [1:0]  bullet_active_o;
  logic [19:0] bullet_left_o;
  logic [19:0] bullet_top_o;
  logic        fired_o;

  int n_tests = 0;
  int n_fail  = 0;

  player_cannon dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .frame_i        (frame_i),
    .move_left_i    (move_left_i),
    .move_right_i   (move_right_i),
    .shoot_i        (shoot_i),
    .hit_i          (hit_i),
    .add_life_i     (add_life_i),
    .hit_enemy_i    (hit_enemy_i),
    .state_o        (state_o),
    .alive_o        (alive_o),
    .lives_o        (lives_o),
    .pos_left_o     (pos_left_o),
    .pos_right_o    (pos_right_o),
    .bullet_active_o(bullet_active_o),
    .bullet_left_o  (bullet_left_o),
    .bullet_top_o   (bullet_top_o),
    .fired_o        (fired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_lives"}, 32'(lives_o), 32'd2);
    check({tag, "_pos"}, 32'(pos_left_o), 32'd300);
    check({tag, "_right"}, 32'(pos_right_o), 32'd340);
    check({tag, "_active"}, 32'(bullet_active_o), 32'd0);
    check({tag, "_top"}, 32'(bullet_top_o),
          (32'd384 << 10) | 32'd384);
    check({tag, "_left"}, 32'(bullet_left_o), 32'd0);
    check({tag, "_fired"}, 32'(fired_o), 32'd0);
    check({tag, "_alive"}, 32'(alive_o), 32'd1);
  endtask

  initial begin
    #12;
    check_reset_vals("rst");
    reset_ni = 1'b1;
    tick();

    // movement and clamping
    move_left_i = 1'b1;
    frames(1);
    check("left1", 32'(pos_left_o), 32'd295);
    frames(69);
    check("left_clamp", 32'(pos_left_o), 32'd9);
    move_left_i  = 1'b0;
    move_right_i = 1'b1;
    frames(200);
    check("right_clamp", 32'(pos_left_o), 32'd589);
    check("right_edge", 32'(pos_right_o), 32'd629);
    move_left_i = 1'b1;
    frames(1);
    check("both_hold", 32'(pos_left_o), 32'd589);
    move_left_i  = 1'b0;
    move_right_i = 1'b0;

    // reset back to start position
    @(posedge clk_i);
    #3 reset_ni = 1'b0;
    #1 check("rst2_pos", 32'(pos_left_o), 32'd300);
    #3 reset_ni = 1'b1;
    tick();

    // first launch: two cycles of latency
    shoot_i = 1'b1;
    tick();
    check("launch_lat_act", 32'(bullet_active_o), 32'd0);
    check("launch_lat_fired", 32'(fired_o), 32'd0);
    tick();
    check("launch0_fired", 32'(fired_o), 32'd1);
    check("launch0_act", 32'(bullet_active_o), 32'd1);
    check("launch0_left", 32'(bullet_left_o[9:0]), 32'd317);
    check("launch0_top", 32'(bullet_top_o[9:0]), 32'd384);

    // second edge dropped by cooldown
    shoot_i = 1'b0;
    tick();
    check("fired_pulse_end", 32'(fired_o), 32'd0);
    shoot_i = 1'b1;
    tick();
    tick();
    check("cool_drop_fired", 32'(fired_o), 32'd0);
    check("cool_drop_act", 32'(bullet_active_o), 32'd1);
    shoot_i = 1'b0;
    tick();

    // after cooldown, slot 1 launches
    frames(8);
    shoot_i = 1'b1;
    tick();
    tick();
    check("launch1_fired", 32'(fired_o), 32'd1);
    check("launch1_act", 32'(bullet_active_o), 32'd3);
    check("launch1_top", 32'(bullet_top_o),
          (32'd384 << 10) | 32'd304);
    check("launch1_left", 32'(bullet_left_o[19:10]), 32'd317);
    shoot_i = 1'b0;
    tick();

    // both slots busy: edge dropped
    frames(8);
    shoot_i = 1'b1;
    tick();
    tick();
    check("busy_drop_fired", 32'(fired_o), 32'd0);
    check("busy_drop_act", 32'(bullet_active_o), 32'd3);
    shoot_i = 1'b0;
    tick();

    // slot 0 flies to the top and retires
    frames(22);
    check("fly_top0", 32'(bullet_top_o[9:0]), 32'd4);
    check("fly_act", 32'(bullet_active_o), 32'd3);
    frames(1);
    check("retire_act", 32'(bullet_active_o), 32'd2);
    check("fly_top1", 32'(bullet_top_o[19:10]), 32'd74);

    // enemy hit on slot 1 with a frame and a launch
    shoot_i = 1'b1;
    tick();
    hit_enemy_i = 2'b10;
    frame_i = 1'b1;
    tick();
    hit_enemy_i = 2'b00;
    frame_i = 1'b0;
    check("enemy_act", 32'(bullet_active_o), 32'd1);
    check("enemy_fired", 32'(fired_o), 32'd1);
    check("enemy_top", 32'(bullet_top_o),
          (32'd74 << 10) | 32'd384);
    shoot_i = 1'b0;

    // first hit and resume
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    check("hit1_state", 32'(state_o), 32'd1);
    check("hit1_lives", 32'(lives_o), 32'd1);
    check("hit1_act", 32'(bullet_active_o), 32'd0);
    shoot_i = 1'b1;
    tick();
    tick();
    check("resume1_state", 32'(state_o), 32'd0);
    check("resume1_pos", 32'(pos_left_o), 32'd300);
    check("resume1_fired", 32'(fired_o), 32'd0);
    check("resume1_act", 32'(bullet_active_o), 32'd0);
    shoot_i = 1'b0;
    tick();

    // second hit
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    check("hit2_state", 32'(state_o), 32'd1);
    check("hit2_lives", 32'(lives_o), 32'd0);
    shoot_i = 1'b1;
    tick();
    tick();
    check("resume2_state", 32'(state_o), 32'd0);
    shoot_i = 1'b0;
    tick();

    // third hit: game over
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    check("over_state", 32'(state_o), 32'd2);
    check("over_alive", 32'(alive_o), 32'd0);
    check("over_lives", 32'(lives_o), 32'd0);
    add_life_i = 1'b1;
    frames(1);
    add_life_i = 1'b0;
    check("over_addlife", 32'(lives_o), 32'd0);
    shoot_i = 1'b1;
    tick();
    tick();
    check("newgame_state", 32'(state_o), 32'd0);
    check("newgame_lives", 32'(lives_o), 32'd2);
    check("newgame_pos", 32'(pos_left_o), 32'd300);
    check("newgame_alive", 32'(alive_o), 32'd1);
    shoot_i = 1'b0;
    tick();

    // extra lives saturate; hit plus life nets zero
    add_life_i = 1'b1;
    frames(2);
    check("life_sat", 32'(lives_o), 32'd3);
    hit_i = 1'b1;
    frames(1);
    hit_i = 1'b0;
    add_life_i = 1'b0;
    check("hit_life_lives", 32'(lives_o), 32'd3);
    check("hit_life_state", 32'(state_o), 32'd1);
    shoot_i = 1'b1;
    tick();
    tick();
    shoot_i = 1'b0;
    tick();

    // async reset mid-flight
    move_left_i = 1'b1;
    frames(1);
    move_left_i = 1'b0;
    check("pre_rst_pos", 32'(pos_left_o), 32'd295);
    shoot_i = 1'b1;
    tick();
    tick();
    check("pre_rst_fired", 32'(fired_o), 32'd1);
    check("pre_rst_left", 32'(bullet_left_o[9:0]), 32'd312);
    shoot_i = 1'b0;
    #2 reset_ni = 1'b0;
    #1 check_reset_vals("arst");
    #3 reset_ni = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_cannon.md
# player_cannon

Parametrised next-generation player ship for the space-invaders datapath. It holds ship position, a lives counter and a play/hit/over state machine, plus a pool of `BULLETS_P` independent bullet slots with a reload cooldown. The block sits between the debounced button inputs and the collision/VGA draw logic. It replaces the single-bullet ship block.

## Interface
- `BULLETS_P`, 2: number of bullet slots, 1..4.
- `SHIP_W_P`, 40: ship width in pixels.
- `STEP_P`, 5: ship pixels per frame.
- `BULLET_STEP_P`, 10: bullet pixels per frame.
- `LEFT_BORDER_P`, 9: minimum `pos_left_o`.
- `RIGHT_BORDER_P`, 629: maximum `pos_right_o`.
- `START_POS_P`, 300: `pos_left_o` after reset, new game, or resume.
- `LAUNCH_TOP_P`, 384: bullet top row at launch.
- `START_LIVES_P`, 2 and `MAX_LIVES_P`, 3: lives at new game, and the saturation cap.
- `COOLDOWN_P`, 8: frames between launches.
- `clk_i` in 1: sole clock.
- `reset_ni` in 1: asynchronous, active-low reset.
- `frame_i` in 1: one-cycle pulse per video frame.
- `move_left_i`, `move_right_i`, `shoot_i`, `hit_i`, `add_life_i` in 1: level inputs.
- `hit_enemy_i` in `BULLETS_P`: bit k retires slot k.
- `state_o` out 2: PLAY=0, HIT=1, OVER=2.
- `alive_o` out 1: high when `state_o`≠OVER.
- `lives_o` out 2: lives remaining.
- `pos_left_o`, `pos_right_o` out 10: ship edges; right = left+`SHIP_W_P`.
- `bullet_active_o` out `BULLETS_P`: slot in flight.
- `bullet_left_o`, `bullet_top_o` out 10×`BULLETS_P`: slot k is in bits [10k+9:10k]. Bullet is 6 wide and 10 tall.
- `fired_o` out 1: one-cycle pulse on launch.

## Operation
- Reset values:
  - state PLAY, lives `START_LIVES_P`, `pos_left_o`=`START_POS_P`.
  - All slots inactive, with `bullet_top_o`=`LAUNCH_TOP_P` and `bullet_left_o`=0.
  - Cooldown 0, `fired_o`=0.
- Shoot edge: `shoot_i` is registered once. `shoot_edge` = `shoot_i` & ~previous.

PLAY state:
- Movement applies on `frame_i` when exactly one of the move inputs is high. Both high or both low means no movement.
- Left move: `pos_left` = max(`pos_left`−`STEP_P`, `LEFT_BORDER_P`).
- Right move: `pos_left` = min(`pos_left`+`STEP_P`, `RIGHT_BORDER_P`−`SHIP_W_P`).
- Clamping is done in 11-bit arithmetic. There is no wrap.
- Launch happens when `shoot_edge`, cooldown==0, and at least one slot is free.
  - The lowest-index free slot is loaded: top=`LAUNCH_TOP_P`, left=`pos_left`+`SHIP_W_P`/2−3.
  - Cooldown is loaded with `COOLDOWN_P` and `fired_o` pulses.
  - If no slot is free, the edge is dropped with no launch.
- Cooldown decrements on `frame_i` and saturates at 0.
- Bullet flight, on `frame_i`:
  - If top ≤ `BULLET_STEP_P`, the slot retires.
  - Otherwise top −= `BULLET_STEP_P`.
- `hit_enemy_i[k]` retires slot k on the next edge regardless of `frame_i`. Retirement beats a same-cycle frame step.
- A slot retired this cycle is not free for a launch in the same cycle.
- `hit_i`:
  - If lives>0: go to HIT, lives −1.
  - If lives==0: go to OVER.
  - `hit_i` has priority over launch and movement in that cycle.
- `add_life_i` & `frame_i`: lives +1, saturating at `MAX_LIVES_P`. Ignored in OVER. If it coincides with a hit, both apply, giving net 0.

HIT state:
- Position is frozen, all slots are cleared, and cooldown is zeroed.
- `shoot_edge` returns to PLAY with `pos_left`=`START_POS_P`. That edge does not launch.

OVER state:
- Same freeze and clear as HIT.
- `shoot_edge` returns to PLAY with lives=`START_LIVES_P` and position reset.

Asynchronous reset mid-flight clears everything immediately.

## Timing
- All state is registered. Every output is a register or a fixed add from registers.
- Launch: `shoot_i` rises in cycle n and `bullet_active_o` is high from n+2. The latency is the edge register plus the slot register.
- Hit: `hit_i` in cycle n gives `state_o`/`lives_o` updated at n+1.
- Frame update: outputs change on the edge after the `frame_i` cycle.

## Structure
- Package `player_pkg` holds:
  - the `play_state_e` enum (PLAY/HIT/OVER);
  - the bullet width and height constants (6, 10);
  - the screen width constant (640).
- Sub-module `bullet_slot`: one slot, containing the active flag, top register and left register.
  - Inputs: load, left value, frame, retire.
  - Instantiate with `generate`.
- The top level holds the FSM, position, lives, cooldown and free-slot priority encoder.

## Test plan
- Reset, then `move_left_i` held for 70 frames → `pos_left_o` steps 300, 295, … and sticks at 9. `move_right_i` held → sticks at 589 (`pos_right_o`=629).
- Three shoot edges 1 cycle apart with cooldown 0 initially:
  - Slot 0 launches at left=317, top=384.
  - The 2nd edge is dropped (cooldown).
  - After 8 frames, slot 1 launches.
  - With both slots busy, a 3rd edge is dropped and `fired_o` stays 0.
- A bullet flies undisturbed → top 384, 374, …, 14, 4, then retires on the next frame. `bullet_active_o`[0] falls.
- `hit_enemy_i`[1] on the same cycle as `frame_i` → slot 1 retired with no step. A shoot edge in that cycle does not reuse slot 1.
- Two hits: lives 2→1 then 1→0, each entering HIT with bullets cleared and resumed by a shoot edge. A third hit → OVER with `alive_o`=0. A shoot edge → PLAY, lives=2, pos=300.
- Assert `reset_ni` low mid-flight, asynchronously between edges → all outputs at reset values before the next edge.
